filter_chain_pipe: RTL
======================

Name: filter_chain_pipe

Overview:
- Parametrised, pipelined successor to the combinational switch-selected filter mux.
- Streams RGB pixels through four fixed, individually enabled stages: grayscale, scramble, invert, then ordered-dither with truncation to the output depth.
- Uses valid/ready handshakes on both sides.
- Latches the switch mode only at start-of-frame, so a frame is never filtered with mixed settings.
- Sits between the pixel source (camera/frame buffer) and the VGA pixel output.

Parameters:
- CH_W, 8, input bits per colour channel (pixel in = 3*CH_W, order R[MSB],G,B).
- OUT_CH_W, 4, output bits per channel (pixel out = 3*OUT_CH_W); CH_W-OUT_CH_W >= 2 required.
- IMG_W, 640, pixels per line, used for dither column/row tracking.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- sw  input  4  mode switches: [0] dither, [1] gray, [2] scramble, [3] invert; sampled only on SOF beat
- pix_in  input  3*CH_W  input pixel
- in_sof  input  1  first pixel of frame, qualified by in_valid
- in_valid  input  1  pix_in valid
- in_ready  output  1  block accepts beat this cycle
- pix_out  output  3*OUT_CH_W  filtered pixel
- out_sof  output  1  out pixel is first of frame
- out_valid  output  1  pix_out valid
- out_ready  input  1  sink accepts beat

Behaviour:
- Reset, asynchronous:
  - All stage valid bits 0; all data, mode and sof registers 0.
  - mode_active = 4'b0000 (full bypass); dither x and y counters = 0.
  - out_valid=0, pix_out=0, out_sof=0.
  - in_ready=0 while rst high.
- Flow control:
  - adv = out_ready | ~out_valid; in_ready = adv & ~rst.
  - On adv, the whole 4-register pipeline shifts one place; bubbles (valid=0) shift through.
  - When adv=0 all registers hold, pix_out is stable and nothing is dropped.
- Accept: beat accepted when in_valid & in_ready.
- Mode latching:
  - On an accepted beat with in_sof=1, the stage-1 mode is sw and mode_active<=sw.
  - On any other accepted beat, the stage-1 mode is mode_active.
  - Mode and sof travel with each pixel through all stages, so a sw change affects only pixels from the next SOF on.
- Latency: 4 cycles from acceptance to out_valid with out_ready held high; throughput 1 pixel/cycle.
- Stage 1, gray (mode[1]):
  - Y = (R + 2G + B) >> 2, computed in CH_W+2 bits, no overflow.
  - R=G=B=Y; else pass through.
- Stage 2, scramble (mode[2]): (R,G,B) -> (G,B,R); else pass through.
- Stage 3, invert (mode[3]): each channel bitwise NOT; else pass through.
- Stage 4, dither + truncate:
  - Offset = Bayer2x2[y0][x0] << (CH_W-OUT_CH_W-2), with Bayer [[0,2],[3,1]] indexed by x0=x[0], y0=y[0].
  - If mode[0], each channel = min(ch + offset, 2^CH_W-1), saturating.
  - Output channel = top OUT_CH_W bits.
  - If mode[0]=0, truncate only.
- Position counters (advance once per accepted beat, at stage 1):
  - Accepted SOF beat uses x=0, y=0; the following pixel gets x=1.
  - x wraps at IMG_W-1 to 0, and the wrap increments y.
  - The position is captured with the pixel so stage 4 uses the accepted pixel's coordinates.
- Boundary cases:
  - SOF mid-line: counters restart at 0,0 immediately.
  - SOF during stall: not accepted, so mode_active is unchanged until the beat is accepted.
  - Reset mid-frame: in-flight pixels are discarded and mode returns to bypass.
  - Pixels before the first SOF after reset use bypass.
- No combinational path from pix_in to pix_out; in_ready depends combinationally on out_ready and out_valid only.

Test Plan:
- Bypass latency: reset, sw=0000, SOF beat pix_in=24'hA5C3F0, out_ready=1 -> out_valid high exactly 4 cycles later, pix_out=12'hACF, out_sof=1.
- Gray+invert: sw=1010 on SOF, pix_in=24'h306090 -> Y=8'h60, inverted 8'h9F -> pix_out=12'h999.
- Scramble: sw=0100, pix_in=24'h123456 -> pix_out=12'h351.
- Dither pattern:
  - Stimulus: sw=0001, IMG_W=2, four pixels 24'h787878 starting at SOF.
  - Required: pix_out 12'h777, 12'h888, 12'h888, 12'h777.
  - Saturation: pix_in 24'hFCFCFC at x=0, y=1 -> 12'hFFF.
- Mode change mid-frame: change sw 0000->0010 after the 3rd pixel (no SOF) -> the rest of the frame stays bypass; next SOF pixel is gray.
- Backpressure/reset:
  - out_ready=0 for 5 cycles with 6 beats offered -> in_ready=0 once out_valid is set, pix_out stable, no beat lost or duplicated after release (compare against a scoreboard).
  - Assert rst mid-stream -> out_valid=0 immediately and mode_active=0000.

Source files
------------

// File: rtl/filter_chain_pipe.sv
// Four-stage pixel filter pipeline: gray, scramble, invert, dither+truncate.
// Mode is latched on start-of-frame and travels with each pixel.
module filter_chain_pipe #(
    parameter int CH_W     = 8,
    parameter int OUT_CH_W = 4,
    parameter int IMG_W    = 640
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              sw,
    input  logic [3*CH_W-1:0]       pix_in,
    input  logic                    in_sof,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [3*OUT_CH_W-1:0]   pix_out,
    output logic                    out_sof,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int PW = 3 * CH_W;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int SH = CH_W - OUT_CH_W - 2;

    logic adv, acc;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & ~rst;
    assign acc      = in_valid & in_ready;

    logic [3:0]    mode_active, mode_in;
    logic [XW-1:0] x, cx;
    logic          y, cy;

    always_comb begin
        mode_in = in_sof ? sw : mode_active;
        cx      = in_sof ? '0 : x;
        cy      = in_sof ? 1'b0 : y;
    end

    // Stage registers; each carries only the mode bits still to be applied.
    logic          v1, v2, v3;
    logic          f1, f2, f3;
    logic [2:0]    m1;
    logic [1:0]    m2;
    logic          m3;
    logic          x1, x2, x3, y1, y2, y3;
    logic [PW-1:0] d1, d2, d3;

    logic [CH_W+1:0] ysum;
    logic [CH_W-1:0] yv;
    logic [PW-1:0]   gin, scr, inv;

    always_comb begin
        ysum = {2'b00, pix_in[PW-1 -: CH_W]}
             + {1'b0, pix_in[2*CH_W-1 -: CH_W], 1'b0}
             + {2'b00, pix_in[CH_W-1:0]};
        yv   = ysum[CH_W+1:2];
        gin  = mode_in[1] ? {yv, yv, yv} : pix_in;
        scr  = m1[1] ? {d1[2*CH_W-1:0], d1[PW-1 -: CH_W]} : d1;
        inv  = m2[1] ? ~d2 : d2;
    end

    logic [1:0]             bay;
    logic [CH_W-1:0]        off;
    logic [3*OUT_CH_W-1:0]  dout;

    always_comb begin
        unique case ({y3, x3})
            2'b00:   bay = 2'd0;
            2'b01:   bay = 2'd2;
            2'b10:   bay = 2'd3;
            default: bay = 2'd1;
        endcase
        off  = CH_W'(bay) << SH;
        dout = '0;
        for (int i = 0; i < 3; i++) begin
            logic [CH_W:0]   s;
            logic [CH_W-1:0] c;
            s = {1'b0, d3[i*CH_W +: CH_W]} + {1'b0, (m3 ? off : '0)};
            c = s[CH_W] ? '1 : s[CH_W-1:0];
            dout[i*OUT_CH_W +: OUT_CH_W] = c[CH_W-1 -: OUT_CH_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_active <= '0;
            x           <= '0;
            y           <= 1'b0;
            {v1, v2, v3, out_valid} <= '0;
            {f1, f2, f3, out_sof}   <= '0;
            m1 <= '0;
            m2 <= '0;
            m3 <= 1'b0;
            {x1, x2, x3, y1, y2, y3} <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
            pix_out <= '0;
        end else if (adv) begin
            if (acc) begin
                if (in_sof)
                    mode_active <= sw;
                if (cx == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= ~cy;
                end else begin
                    x <= cx + 1'b1;
                    y <= cy;
                end
            end
            v1 <= acc;
            f1 <= acc & in_sof;
            m1 <= {mode_in[3], mode_in[2], mode_in[0]};
            x1 <= cx[0];
            y1 <= cy;
            d1 <= gin;

            v2 <= v1;
            f2 <= f1;
            m2 <= {m1[2], m1[0]};
            x2 <= x1;
            y2 <= y1;
            d2 <= scr;

            v3 <= v2;
            f3 <= f2;
            m3 <= m2[0];
            x3 <= x2;
            y3 <= y2;
            d3 <= inv;

            out_valid <= v3;
            out_sof   <= f3;
            pix_out   <= dout;
        end
    end

endmodule
